// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and timing helpers for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAITIDLE
  } state_t;

  typedef logic [3:0] bit_idx_t;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz, input int unsigned us);
    logic [63:0] prod;
    prod = 64'(freq_hz) * 64'(us) / 64'd1000000;
    return prod[31:0];
  endfunction

  localparam int unsigned INHIBIT_CYCLES = us_to_cycles(100000000, 100);
  localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(100000000, 15000);

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchronizer, stability filter and falling-edge strobe for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall_edge
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync;
  logic [RUN_W-1:0] run;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= 2'b11;
      run       <= '0;
      level     <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      sync      <= {sync[0], line};
      fall_edge <= 1'b0;
      if (sync[1] == level) begin
        run <= '0;
      end else if (run == RUN_W'(FILTER_LEN - 1)) begin
        level     <= sync[1];
        run       <= '0;
        fall_edge <= level;
      end else begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_transmitter.sv
// rtl/ps2_host_transmitter.sv - sends one host-to-device command byte over the PS/2 bus
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUNCY = 100000000,
  parameter int unsigned INHIBIT_US     = 100,
  parameter int unsigned TIMEOUT_US     = 15000,
  parameter int          FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txStart,
  input  logic [7:0] txData,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       ps2ClkDriveLow,
  output logic       ps2DataDriveLow,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError
);

  localparam int unsigned INHIBIT_LEN = us_to_cycles(CLOCK_FREQUNCY, INHIBIT_US);
  localparam int unsigned TIMEOUT_LEN = us_to_cycles(CLOCK_FREQUNCY, TIMEOUT_US);
  localparam int unsigned CNT_MAX     = (INHIBIT_LEN > TIMEOUT_LEN) ? INHIBIT_LEN : TIMEOUT_LEN;
  localparam int          CNT_W       = $clog2(CNT_MAX + 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  bit_idx_t         bit_idx;
  logic [7:0]       data_q;
  logic             parity_q, data_drive_q, ack_q, done_q, error_q;
  logic             clk_level, clk_fall, data_level, data_fall_unused;
  logic             inhibit_done, timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .line(ps2Clk), .level(clk_level), .fall_edge(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst(rst), .line(ps2Data), .level(data_level), .fall_edge(data_fall_unused)
  );

  assign inhibit_done = (count == CNT_W'(INHIBIT_LEN - 1));
  // A device clock edge in the same cycle rescues the frame from timing out.
  assign timeout = (count == CNT_W'(TIMEOUT_LEN - 1)) && !clk_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      bit_idx      <= '0;
      data_q       <= '0;
      parity_q     <= 1'b0;
      data_drive_q <= 1'b0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state   <= next_state;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          count        <= '0;
          data_drive_q <= 1'b0;
          if (txStart) begin
            data_q   <= txData;
            parity_q <= ~^txData;
            bit_idx  <= '0;
          end
        end
        ST_INHIBIT: begin
          count <= inhibit_done ? '0 : count + 1'b1;
          if (inhibit_done) data_drive_q <= 1'b1;
        end
        default: begin
          count <= clk_fall ? '0 : count + 1'b1;
          if (timeout) begin
            error_q      <= 1'b1;
            data_drive_q <= 1'b0;
          end else if (state == ST_SEND && clk_fall) begin
            if (bit_idx < 4'd8)       data_drive_q <= ~data_q[bit_idx[2:0]];
            else if (bit_idx == 4'd8) data_drive_q <= ~parity_q;
            else                      data_drive_q <= 1'b0;
            bit_idx <= bit_idx + 1'b1;
          end else if (state == ST_ACK && clk_fall) begin
            ack_q <= ~data_level;
          end else if (state == ST_WAITIDLE && clk_level && data_level) begin
            done_q  <= ack_q;
            error_q <= ~ack_q;
          end
        end
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (txStart) next_state = ST_INHIBIT;
      ST_INHIBIT:  if (inhibit_done) next_state = ST_RTS;
      ST_RTS:      if (timeout) next_state = ST_IDLE;
                   else if (clk_fall) next_state = ST_SEND;
      ST_SEND:     if (timeout) next_state = ST_IDLE;
                   else if (clk_fall && bit_idx == 4'd9) next_state = ST_ACK;
      ST_ACK:      if (timeout) next_state = ST_IDLE;
                   else if (clk_fall) next_state = ST_WAITIDLE;
      ST_WAITIDLE: if (timeout || (clk_level && data_level)) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ps2ClkDriveLow  = (state == ST_INHIBIT);
    ps2DataDriveLow = data_drive_q && (state == ST_RTS || state == ST_SEND);
    txBusy          = (state != ST_IDLE);
    txDone          = done_q;
    txError         = error_q;
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb/tb_ps2_host_transmitter.sv - self-checking bench with a behavioural PS/2 device model
module tb_ps2_host_transmitter;

  localparam int FREQ    = 1000000;
  localparam int INH_US  = 100;
  localparam int TO_US   = 600;
  localparam int FL      = 8;
  localparam int INH_CYC = FREQ / 1000000 * INH_US;
  localparam int TO_CYC  = FREQ / 1000000 * TO_US;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2Clk, ps2Data;
  logic       ps2ClkDriveLow, ps2DataDriveLow, txBusy, txDone, txError;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int pulse_bad = 0;
  logic prev_busy = 1'b0;

  assign ps2Clk  = ~(ps2ClkDriveLow | dev_clk_low);
  assign ps2Data = ~(ps2DataDriveLow | dev_data_low);

  ps2_host_transmitter #(
    .CLOCK_FREQUNCY(FREQ), .INHIBIT_US(INH_US), .TIMEOUT_US(TO_US), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .txStart(txStart), .txData(txData),
    .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .ps2ClkDriveLow(ps2ClkDriveLow), .ps2DataDriveLow(ps2DataDriveLow),
    .txBusy(txBusy), .txDone(txDone), .txError(txError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (txDone) done_cnt++;
      if (txError) err_cnt++;
      if ((txDone || txError) && (txBusy || !prev_busy)) pulse_bad++;
      if (txDone && txError) pulse_bad++;
    end
    prev_busy = txBusy;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] expected_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = ($countones(d) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic clear_counts();
    done_cnt = 0;
    err_cnt = 0;
    pulse_bad = 0;
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    txData = d;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
  endtask

  task automatic wait_rts(output int inh, output bit ok);
    int guard = 0;
    inh = 0;
    while (!(ps2DataDriveLow && !ps2ClkDriveLow) && guard < 4 * INH_CYC + 50) begin
      if (ps2ClkDriveLow) inh++;
      @(negedge clk);
      guard++;
    end
    ok = (ps2DataDriveLow && !ps2ClkDriveLow);
  endtask

  task automatic device_frame(input int h, input bit do_ack, input bit glitch, input int abort_at,
                              output logic [10:0] got, output bit completed);
    got = '0;
    completed = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (h / 2) @(negedge clk);
      got[i] = ps2Data;
      if (i == abort_at) return;
      if (glitch && i == 4) begin
        txData = 8'($urandom);
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (h - h / 2 - 4) @(negedge clk);
      end else begin
        repeat (h - h / 2) @(negedge clk);
      end
    end
    if (do_ack) dev_data_low = 1'b1;
    repeat (10) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (h) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (h / 2) @(negedge clk);
    dev_data_low = 1'b0;
    completed = 1'b1;
  endtask

  task automatic wait_idle(input int h, output bit ok);
    int guard = 0;
    while (txBusy && guard < 8 * h + 400) begin
      @(negedge clk);
      guard++;
    end
    ok = !txBusy;
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input int h,
                            input bit do_ack, input bit glitch);
    int inh;
    bit ok, completed;
    logic [10:0] got, exp;
    clear_counts();
    start_tx(d);
    wait_rts(inh, ok);
    checks++;
    if (!ok || inh != INH_CYC) begin
      errors++;
      $display("FAIL %s inhibit: got %0d cycles (rts=%0d), want %0d", name, inh, ok, INH_CYC);
    end
    device_frame(h, do_ack, glitch, -1, got, completed);
    exp = expected_frame(d);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s frame: got %b, want %b", name, got, exp);
    end
    wait_idle(h, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s busy_drop: txBusy still %b, want 0", name, txBusy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== (do_ack ? 1 : 0) || err_cnt !== (do_ack ? 0 : 1)) begin
      errors++;
      $display("FAIL %s pulses: got done=%0d err=%0d, want done=%0d err=%0d",
               name, done_cnt, err_cnt, do_ack ? 1 : 0, do_ack ? 0 : 1);
    end
    checks++;
    if (pulse_bad !== 0) begin
      errors++;
      $display("FAIL %s pulse_timing: got %0d bad pulses, want 0", name, pulse_bad);
    end
    checks++;
    if ({ps2ClkDriveLow, ps2DataDriveLow} !== 2'b00) begin
      errors++;
      $display("FAIL %s released: got drives %b, want 00", name, {ps2ClkDriveLow, ps2DataDriveLow});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2ClkDriveLow, ps2DataDriveLow, txBusy, txDone, txError} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: got %b, want 00000",
               {ps2ClkDriveLow, ps2DataDriveLow, txBusy, txDone, txError});
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({ps2ClkDriveLow, ps2DataDriveLow, txBusy, txDone, txError} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b, want 00000",
               {ps2ClkDriveLow, ps2DataDriveLow, txBusy, txDone, txError});
    end
  endtask

  task automatic test_timeout();
    int inh, n;
    bit ok;
    clear_counts();
    start_tx(8'hFF);
    wait_rts(inh, ok);
    n = 0;
    while (!txError && n < TO_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok || n != TO_CYC) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, want %0d", n, TO_CYC);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2ClkDriveLow, ps2DataDriveLow, txBusy} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_release: got %b, want 000", {ps2ClkDriveLow, ps2DataDriveLow, txBusy});
    end
    checks++;
    if (err_cnt !== 1 || done_cnt !== 0 || pulse_bad !== 0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%0d done=%0d bad=%0d, want 1 0 0", err_cnt, done_cnt, pulse_bad);
    end
  endtask

  task automatic test_reset_midframe();
    int inh;
    bit ok, completed;
    logic [10:0] got;
    clear_counts();
    start_tx(8'hED);
    wait_rts(inh, ok);
    device_frame(40, 1'b1, 1'b0, 4, got, completed);
    rst = 1'b0;
    #1;
    checks++;
    if ({ps2ClkDriveLow, ps2DataDriveLow, txBusy} !== 3'b000 || !ok) begin
      errors++;
      $display("FAIL midframe_reset: got %b, want 000", {ps2ClkDriveLow, ps2DataDriveLow, txBusy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || err_cnt !== 0 || txBusy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_pulse: got done=%0d err=%0d busy=%b, want 0 0 0", done_cnt, err_cnt, txBusy);
    end
    test_frame("after_reset_01", 8'h01, 40, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      int h;
      bit a;
      d = 8'($urandom);
      h = $urandom_range(25, 60);
      a = 1'($urandom);
      test_frame("random", d, h, a, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_frame("cmd_ed", 8'hED, 40, 1'b1, 1'b0);
    test_frame("cmd_f4", 8'hF4, 40, 1'b1, 1'b0);
    test_frame("no_ack", 8'hFF, 40, 1'b0, 1'b0);
    test_timeout();
    test_reset_midframe();
    test_frame("busy_glitch", 8'hA5, 40, 1'b1, 1'b1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_transmitter.md
# ps2_host_transmitter

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the attached keyboard over the open-drain ps2Clk/ps2Data lines. It is the opposite direction to the existing keyboard scan-code receiver and shares the same two bus wires. While `txBusy` is high, the receiver must ignore the bus; that gating is done at the top level.

## Interface
- `CLOCK_FREQUNCY`, 100000000: system clock frequency in Hz.
- `INHIBIT_US`, 100: time the clock line is held low before the request-to-send.
- `TIMEOUT_US`, 15000: maximum allowed gap between consecutive device clock falling edges.
- `FILTER_LEN`, 8: number of consecutive equal samples required to accept a new level on an input line.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `txStart`  in  1  one-cycle request to send `txData`.
- `txData`  in  8  command byte.
- `ps2Clk`  in  1  raw PS/2 clock line, asynchronous to `clk`.
- `ps2Data`  in  1  raw PS/2 data line, asynchronous to `clk`.
- `ps2ClkDriveLow`  out  1  1 = pull the clock line low; 0 = release it (high-Z).
- `ps2DataDriveLow`  out  1  1 = pull the data line low; 0 = release it.
- `txBusy`  out  1  high from the cycle after start is accepted until the return to IDLE.
- `txDone`  out  1  one-cycle pulse: the device acknowledged the byte.
- `txError`  out  1  one-cycle pulse: no acknowledge, or a timeout occurred.

## Operation
- Both input lines pass through a 2-FF synchronizer and then a FILTER_LEN stability filter.
- `fallEdge` is a one-cycle strobe generated when the filtered clock goes from 1 to 0.
- `txStart` is accepted only in IDLE; it is ignored in every other state.
- On acceptance, latch `txData` and compute `parity = ~^txData` (odd parity).

States:
- **IDLE**: both drives 0, `txBusy` 0.
- **INHIBIT**: `ps2ClkDriveLow`=1 for exactly INHIBIT_US×CLOCK_FREQUNCY/1e6 cycles.
- **RTS**: `ps2DataDriveLow`=1 (start bit); clock released in the same cycle. Wait for `fallEdge`.
- **SEND**: this state is entered with bitIdx=0 on the first `fallEdge`. On each `fallEdge`, drive the current bit, then increment bitIdx:
  - bitIdx 0..7: `ps2DataDriveLow` = ~txData[bitIdx], LSB first.
  - bitIdx 8: drive ~parity.
  - bitIdx 9: release data (stop bit), then go to ACK.
- **ACK**: on the next `fallEdge`, sample filtered data.
  - 0: go to WAITIDLE with ack=1.
  - 1: go to WAITIDLE with ack=0.
- **WAITIDLE**: wait until filtered clock and data are both 1.
  - Then pulse `txDone` if ack=1, otherwise pulse `txError`.
  - Return to IDLE.

Timeout:
- A counter runs in RTS, SEND, ACK and WAITIDLE and is cleared on every `fallEdge`.
- When it reaches TIMEOUT_US worth of cycles: release both lines, pulse `txError`, go to IDLE.

Reset:
- Async reset forces IDLE and sets every output to 0, including the drive signals (bus released).
- This applies mid-frame as well; no pulse is emitted.

## Timing
- `txBusy` rises the cycle after `txStart` and falls in the same cycle as the `txDone`/`txError` pulse.
- Clock drive: rises the cycle after `txStart`; falls on the cycle the inhibit count expires, which is the same cycle the data drive rises.
- Data-line updates occur 1 cycle after `fallEdge`. `fallEdge` itself lags the physical edge by 2 + FILTER_LEN cycles.
- `txDone` and `txError` are mutually exclusive and at most one pulse is issued per frame.
- Glitches shorter than FILTER_LEN cycles on either line produce no edge.

## Structure
- Package `ps2_pkg` holds:
  - the state enum;
  - derived constants `INHIBIT_CYCLES`, `TIMEOUT_CYCLES`;
  - a 4-bit bit-index type.
- Sub-module `ps2_line_filter` (synchronizer + stability filter + falling-edge strobe) is instantiated once per line. It is natural to reuse it on the receiver side.

## Test plan
- `txData`=0xED with a device model that acks:
  - clock held low for 10000 cycles, then start bit 0;
  - bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `txDone` pulses once, `txBusy` drops.
- `txData`=0xF4: bits 0,0,1,0,1,1,1,1, parity 0; ack received → `txDone`.
- Device model does not pull data low in the ACK slot → `txError`=1 for one cycle, no `txDone`.
- Device never clocks after RTS → `txError` after 1,500,000 cycles; both drive outputs return to 0.
- `rst` asserted after the 4th data bit → drives 0 immediately and no pulse is issued. A subsequent `txStart` of 0x01 completes correctly with parity 0.
- `txStart` pulsed again while busy, plus 3-cycle glitches on ps2Clk → both ignored; frame bits unchanged.
